// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory-access stage and its data memory.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
// Contents: ResultSrc encodings, MEM FSM state enum, funct3 load/store codes,
//           M/W register layout, sub-word lane helpers.
package riscv_pkg;

  // ResultSrc encodings; RES_MEM marks a load.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Load funct3 codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access sequencer states (only used when the memory has wait states).
  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_DONE
  } mem_state_t;

  // M/W pipeline register contents.
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } mw_reg_t;

  // Byte write enables for a store. size = funct3[1:0]: 00 byte, 01 half,
  // anything else a full word. Misaligned halves/words snap to alignment.
  function automatic logic [3:0] store_byte_en(input logic [1:0] size,
                                               input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate store data across all lanes so the byte enables pick the lane.
  function automatic logic [31:0] store_lanes(input logic [31:0] data,
                                              input logic [1:0]  size);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Select the addressed lane of a read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables.
// Latency: read combinational, write committed at the clock edge.
// Backpressure: none; accepts a write on any cycle with a non-zero byte_en.
// Ports: clk; addr = word index; byte_en/wdata = write port; rdata = read port.
module data_memory #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        byte_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // Contents deliberately survive reset.
  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the RV32I pipeline: data-memory access plus the M/W register.
// Latency: 1 cycle with MEM_LATENCY=0; an access otherwise completes MEM_LATENCY cycles after it is first seen.
// Backpressure: StallM holds the upstream stages while an access is in flight; M/W takes bubbles meanwhile.
// Ports: clk, rst (async active-low); E/M inputs *M; Funct3M only with DMEM_SUBWORD_EN;
//        StallM to the hazard unit; M/W register outputs *W.
// Build option: define DMEM_SUBWORD_EN for byte/halfword loads and stores.
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
`ifdef DMEM_SUBWORD_EN
  input  logic [2:0]  Funct3M,
`endif
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W
);

  logic        stall_raw;
  logic        write_raw;
  logic        do_write;
  logic [3:0]  byte_en_req;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  mw_reg_t     mw_d;
  mw_reg_t     mw_q;

  // ---------------------------------------------------------------------------
  // Lane handling
  // ---------------------------------------------------------------------------
`ifdef DMEM_SUBWORD_EN
  assign byte_en_req = store_byte_en(Funct3M[1:0], ALUResultM[1:0]);
  assign wr_lanes    = store_lanes(WriteDataM, Funct3M[1:0]);
  assign load_data   = load_extend(mem_rdata, Funct3M[1:0], Funct3M[2], ALUResultM[1:0]);
`else
  assign byte_en_req = 4'b1111;
  assign wr_lanes    = WriteDataM;
  assign load_data   = mem_rdata;
`endif

  // ---------------------------------------------------------------------------
  // Access sequencing
  // ---------------------------------------------------------------------------
  generate
    if (MEM_LATENCY == 0) begin : g_single_cycle
      assign stall_raw = 1'b0;
      assign write_raw = MemWriteM;
    end else begin : g_wait_states
      localparam int CW = $clog2(MEM_LATENCY + 1);

      logic          access;
      mem_state_t    state_q;
      mem_state_t    state_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          stall_c;
      logic          write_c;

      assign access = MemWriteM | (ResultSrcM == RES_MEM);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= MEM_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Upstream holds the M inputs for the whole access, so the store is
      // committed only on the DONE edge and exactly once.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        write_c = 1'b0;
        case (state_q)
          MEM_IDLE: begin
            if (access) begin
              stall_c = 1'b1;
              if (MEM_LATENCY == 1) begin
                state_d = MEM_DONE;
              end else begin
                state_d = MEM_WAIT;
                cnt_d   = CW'(1);
              end
            end
          end
          MEM_WAIT: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(MEM_LATENCY - 1)) begin
              state_d = MEM_DONE;
            end
          end
          MEM_DONE: begin
            write_c = MemWriteM;
            state_d = MEM_IDLE;
            cnt_d   = '0;
          end
          default: begin
            state_d = MEM_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign stall_raw = stall_c;
      assign write_raw = write_c;
    end
  endgenerate

  // Reset masks the stall and the write in the same cycle, so an access
  // interrupted by reset never commits and never holds the pipeline.
  assign StallM   = rst & stall_raw;
  assign do_write = rst & write_raw;
  assign byte_en  = do_write ? byte_en_req : 4'b0000;

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  data_memory #(
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .addr    (ALUResultM[ADDR_W+1:2]),
    .byte_en (byte_en),
    .wdata   (wr_lanes),
    .rdata   (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // M/W pipeline register
  // ---------------------------------------------------------------------------
  // Read data is sampled before the edge, so a load+store returns the old word.
  assign mw_d = '{
    reg_write:  RegWriteM,
    result_src: ResultSrcM,
    read_data:  load_data,
    alu_result: ALUResultM,
    rd:         RdM,
    pc_plus4:   PCPlus4M
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw_q <= '0;
    end else if (StallM) begin
      mw_q <= '0;
    end else begin
      mw_q <= mw_d;
    end
  end

  assign RegWriteW  = mw_q.reg_write;
  assign ResultSrcW = mw_q.result_src;
  assign ReadDataW  = mw_q.read_data;
  assign ALUResultW = mw_q.alu_result;
  assign RdW        = mw_q.rd;
  assign PCPlus4W   = mw_q.pc_plus4;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: one single-cycle instance (L=0) and one
// three-wait-state instance (L=3), checked against a byte-addressed memory model.
// Define DMEM_SUBWORD_EN to exercise the sub-word load/store paths as well.
module tb_memory_access_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [2:0]  f3;
  } m_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  m_t   in0, in3;

  logic        stall0, rw0, stall3, rw3;
  logic [1:0]  rs0, rs3;
  logic [31:0] rdat0, alu0, pc0, rdat3, alu3, pc3;
  logic [4:0]  rd0, rd3;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference memories: byte arrays plus a per-word "known contents" flag.
  logic [7:0] m0 [1024];
  logic [7:0] m3 [1024];
  bit         v0 [256];
  bit         v3 [256];

  memory_access_stage #(.ADDR_W(8), .MEM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .RegWriteM(in0.rw), .ResultSrcM(in0.rs), .MemWriteM(in0.mw),
    .ALUResultM(in0.alu), .WriteDataM(in0.wd), .RdM(in0.rd), .PCPlus4M(in0.pc),
`ifdef DMEM_SUBWORD_EN
    .Funct3M(in0.f3),
`endif
    .StallM(stall0), .RegWriteW(rw0), .ResultSrcW(rs0), .ReadDataW(rdat0),
    .ALUResultW(alu0), .RdW(rd0), .PCPlus4W(pc0)
  );

  memory_access_stage #(.ADDR_W(8), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .RegWriteM(in3.rw), .ResultSrcM(in3.rs), .MemWriteM(in3.mw),
    .ALUResultM(in3.alu), .WriteDataM(in3.wd), .RdM(in3.rd), .PCPlus4M(in3.pc),
`ifdef DMEM_SUBWORD_EN
    .Funct3M(in3.f3),
`endif
    .StallM(stall3), .RegWriteW(rw3), .ResultSrcW(rs3), .ReadDataW(rdat3),
    .ALUResultW(alu3), .RdW(rd3), .PCPlus4W(pc3)
  );

  function automatic m_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [4:0] rd, input logic [31:0] pc,
                            input logic [2:0] f3);
    m_t v;
    v = '{rw: rw, rs: rs, mw: mw, alu: alu, wd: wd, rd: rd, pc: pc, f3: f3};
    return v;
  endfunction

  function automatic logic [71:0] wmeta(input int d);
    return (d == 0) ? {rw0, rs0, alu0, rd0, pc0} : {rw3, rs3, alu3, rd3, pc3};
  endfunction

  function automatic logic [31:0] wrd(input int d);
    return (d == 0) ? rdat0 : rdat3;
  endfunction

  function automatic logic wstall(input int d);
    return (d == 0) ? stall0 : stall3;
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input m_t v);
    if (d == 0) in0 = v;
    else        in3 = v;
  endtask

  // Model of one access: returns what the load path shows before the edge,
  // then applies the store (if any) to the byte image.
  task automatic model_access(input int d, input m_t op,
                              output logic [31:0] rdat, output bit rv);
    int w, lane, nb;
    logic [31:0] raw;
    w    = int'(op.alu[9:2]);
    nb   = 4;
    lane = 0;
`ifdef DMEM_SUBWORD_EN
    case (op.f3[1:0])
      2'b00:   begin nb = 1; lane = int'(op.alu[1:0]); end
      2'b01:   begin nb = 2; lane = op.alu[1] ? 2 : 0; end
      default: begin nb = 4; lane = 0; end
    endcase
`endif
    raw = '0;
    for (int k = 0; k < nb; k++)
      raw[8*k +: 8] = (d == 0) ? m0[w*4+lane+k] : m3[w*4+lane+k];
    for (int b = 8*nb; b < 32; b++)
      raw[b] = op.f3[2] ? 1'b0 : raw[8*nb-1];
    rdat = raw;
    rv   = (d == 0) ? v0[w] : v3[w];
    if (op.mw) begin
      for (int k = 0; k < nb; k++) begin
        if (d == 0) m0[w*4+lane+k] = op.wd[8*k +: 8];
        else        m3[w*4+lane+k] = op.wd[8*k +: 8];
      end
      if (nb == 4) begin
        if (d == 0) v0[w] = 1'b1;
        else        v3[w] = 1'b1;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction lands in M/W.
  task automatic run_op(input int d, input m_t op);
    logic [31:0] exp_rd;
    bit rv;
    int lat;
    model_access(d, op, exp_rd, rv);
    drive(d, op);
    lat = ((d == 3) && (op.mw || op.rs == RES_MEM)) ? 3 : 0;
    for (int i = 0; i < lat; i++) begin
      #4;
      check("stall_high", 72'(wstall(d)), 72'(1));
      @(posedge clk); #1;
      check("bubble_meta", wmeta(d), 72'(0));
      check("bubble_rdata", 72'(wrd(d)), 72'(0));
    end
    #4;
    check("stall_low", 72'(wstall(d)), 72'(0));
    @(posedge clk); #1;
    check("w_meta", wmeta(d), {op.rw, op.rs, op.alu, op.rd, op.pc});
    if (rv) check("w_rdata", 72'(wrd(d)), 72'(exp_rd));
    drive(d, mk(0, RES_ALU, 0, 32'h0, 32'h0, 5'd0, 32'h0, F3_LW));
  endtask

`ifdef DMEM_SUBWORD_EN
  logic [2:0] ld_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  logic [2:0] st_f3 [3] = '{F3_SB, F3_SH, F3_SW};
`endif

  initial begin
    logic [31:0] r, a;
    int d, kind;
    m_t op;

    rst = 1'b0;
    in0 = mk(0, RES_ALU, 0, 32'h0, 32'h0, 5'd0, 32'h0, F3_LW);
    in3 = in0;
    #1;
    check("rst_stall0", 72'(stall0), 72'(0));
    check("rst_stall3", 72'(stall3), 72'(0));
    check("rst_w0", {wmeta(0), rdat0}, 72'(0));
    check("rst_w3", {wmeta(3), rdat3}, 72'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Fill both memories with known words; upper address bits are random to
    // exercise the modulo-depth wrap on the way in.
    for (int w = 0; w < 256; w++) begin
      r = $urandom;
      a = {r[31:10], 8'(w), 2'b00};
      run_op(0, mk(0, RES_ALU, 1, a, $urandom, 5'd0, 32'h100, F3_SW));
      r = $urandom;
      a = {r[31:10], 8'(w), 2'b00};
      run_op(3, mk(0, RES_ALU, 1, a, $urandom, 5'd0, 32'h200, F3_SW));
    end

    // Single-cycle store then load.
    run_op(0, mk(0, RES_ALU, 1, 32'h10, 32'hDEADBEEF, 5'd0, 32'h14, F3_SW));
    run_op(0, mk(1, RES_MEM, 0, 32'h10, 32'h0, 5'd5, 32'h18, F3_LW));
    check("l0_load_data", 72'(rdat0), 72'(32'hDEADBEEF));
    check("l0_load_rd", 72'(rd0), 72'(5));
    check("l0_load_we", 72'(rw0), 72'(1));

    // Three-wait-state store then load.
    run_op(3, mk(0, RES_ALU, 1, 32'h10, 32'hDEADBEEF, 5'd0, 32'h24, F3_SW));
    run_op(3, mk(1, RES_MEM, 0, 32'h10, 32'h0, 5'd7, 32'h28, F3_LW));
    check("l3_load_data", 72'(rdat3), 72'(32'hDEADBEEF));
    check("l3_load_rd", 72'(rd3), 72'(7));

    // Address wrap modulo depth.
    run_op(0, mk(0, RES_ALU, 1, 32'h400, 32'h1234, 5'd0, 32'h30, F3_SW));
    run_op(0, mk(1, RES_MEM, 0, 32'h0, 32'h0, 5'd3, 32'h34, F3_LW));
    check("wrap_l0", 72'(rdat0), 72'(32'h1234));
    run_op(3, mk(0, RES_ALU, 1, 32'h400, 32'h1234, 5'd0, 32'h30, F3_SW));
    run_op(3, mk(1, RES_MEM, 0, 32'h0, 32'h0, 5'd3, 32'h34, F3_LW));
    check("wrap_l3", 72'(rdat3), 72'(32'h1234));

    // Load and store flagged together: old data out, new data stored.
    run_op(3, mk(0, RES_ALU, 1, 32'h20, 32'h11112222, 5'd0, 32'h40, F3_SW));
    run_op(3, mk(1, RES_MEM, 1, 32'h20, 32'hCAFEF00D, 5'd9, 32'h44, F3_LW));
    check("ldst_old", 72'(rdat3), 72'(32'h11112222));
    run_op(3, mk(1, RES_MEM, 0, 32'h20, 32'h0, 5'd9, 32'h48, F3_LW));
    check("ldst_new", 72'(rdat3), 72'(32'hCAFEF00D));

    // Reset one stall cycle into a store: nothing may be written.
    run_op(3, mk(0, RES_ALU, 1, 32'h44, 32'hA5A50001, 5'd0, 32'h50, F3_SW));
    in3 = mk(0, RES_ALU, 1, 32'h44, 32'h0BAD0BAD, 5'd0, 32'h54, F3_SW);
    #4;
    check("rstmid_stall_before", 72'(stall3), 72'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid_stall3", 72'(stall3), 72'(0));
    check("rstmid_w3", {wmeta(3), rdat3}, 72'(0));
    check("rstmid_w0", {wmeta(0), rdat0}, 72'(0));
    in3 = mk(0, RES_ALU, 0, 32'h0, 32'h0, 5'd0, 32'h0, F3_LW);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_op(3, mk(1, RES_MEM, 0, 32'h44, 32'h0, 5'd4, 32'h58, F3_LW));
    check("rstmid_keep", 72'(rdat3), 72'(32'hA5A50001));

`ifdef DMEM_SUBWORD_EN
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 0 : 3;
      run_op(d, mk(0, RES_ALU, 1, 32'h10, 32'h0, 5'd0, 32'h60, F3_SW));
      run_op(d, mk(0, RES_ALU, 1, 32'h11, 32'hFF, 5'd0, 32'h64, F3_SB));
      run_op(d, mk(1, RES_MEM, 0, 32'h10, 32'h0, 5'd1, 32'h68, F3_LW));
      check("sb_lw", 72'(wrd(d)), 72'(32'h0000FF00));
      run_op(d, mk(1, RES_MEM, 0, 32'h11, 32'h0, 5'd2, 32'h6C, F3_LB));
      check("lb_sext", 72'(wrd(d)), 72'(32'hFFFFFFFF));
      run_op(d, mk(1, RES_MEM, 0, 32'h11, 32'h0, 5'd3, 32'h70, F3_LBU));
      check("lbu_zext", 72'(wrd(d)), 72'(32'h000000FF));
    end
`endif

    // Random mix of ALU ops, loads, stores and load+store on both instances.
    for (int i = 0; i < 400; i++) begin
      r    = $urandom;
      d    = r[12] ? 3 : 0;
      kind = int'(r[14:13]);
      op   = mk(r[5], r[6] ? RES_PC4 : RES_ALU, 0, $urandom, $urandom, r[4:0], $urandom, F3_LW);
      if (kind == 1 || kind == 3) op.rs = RES_MEM;
      if (kind >= 2) op.mw = 1'b1;
`ifdef DMEM_SUBWORD_EN
      if (op.mw) op.f3 = st_f3[int'(r[9:8]) % 3];
      else       op.f3 = ld_f3[int'(r[11:8]) % 5];
`endif
      run_op(d, op);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
